pong_game_ctrl: RTL and testbench

//  Frame-synchronous Pong game sequencer. Sits beside vga_timing and draw_bg in top_vga.

---
 rtl/pong_pkg.sv | 43 ++++
 rtl/pong_paddle.sv | 28 ++
 rtl/pong_game_ctrl.sv | 132 +++++++++++++
 tb/tb_pong_game_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and geometry for the Pong sequencer: state encoding, screen/object
// sizes and the signed-coordinate helper used by the physics.
package pong_pkg;
  localparam int CW = 11;
  typedef logic [CW-1:0]        coord_t;
  typedef logic signed [CW:0]   scoord_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam coord_t H_ACT     = 11'd800;
  localparam coord_t V_ACT     = 11'd600;
  localparam coord_t PADDLE_W  = 11'd10;
  localparam coord_t PADDLE_H  = 11'd80;
  localparam coord_t PADDLE_XL = 11'd16;
  localparam coord_t PADDLE_XR = H_ACT - 11'd16 - PADDLE_W;
  localparam coord_t BALL_SZ   = 11'd10;
  localparam coord_t BALL_SPD  = 11'd4;
  localparam coord_t PAD_SPD   = 11'd6;

  localparam coord_t BALL_X0   = (H_ACT - BALL_SZ) >> 1;
  localparam coord_t BALL_Y0   = (V_ACT - BALL_SZ) >> 1;
  localparam coord_t PAD_Y0    = (V_ACT - PADDLE_H) >> 1;
  localparam coord_t PAD_MAX   = V_ACT - PADDLE_H;
  localparam coord_t BALL_XMAX = H_ACT - BALL_SZ;
  localparam coord_t BALL_YMAX = V_ACT - BALL_SZ;
  // ball x after bouncing off the left / right paddle face
  localparam coord_t L_STOP    = PADDLE_XL + PADDLE_W;
  localparam coord_t R_STOP    = PADDLE_XR - BALL_SZ;

  localparam logic [3:0] WIN_SCORE = 4'd5;
  localparam logic [3:0] SCORE_MAX = 4'd15;
  localparam logic [5:0] HOLD_FRM  = 6'd60;

  function automatic scoord_t s12(coord_t c);
    return $signed({1'b0, c});
  endfunction
endpackage

// File: rtl/pong_paddle.sv
// One paddle: steps PAD_SPD up or down per enabled frame tick, clamped to the screen.
module pong_paddle import pong_pkg::*; (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          en,
  input  logic          up,
  input  logic          dn,
  output logic [CW-1:0] y
);
  scoord_t yn;

  // both or neither pressed leaves the paddle where it is
  always_comb begin
    yn = s12(y);
    if (up && !dn)      yn = s12(y) - s12(PAD_SPD);
    else if (dn && !up) yn = s12(y) + s12(PAD_SPD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  y <= PAD_Y0;
    else if (tick && en) begin
      if (yn < 12'sd0)         y <= '0;
      else if (yn > s12(PAD_MAX)) y <= PAD_MAX;
      else                     y <= yn[CW-1:0];
    end
  end
endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-synchronous Pong sequencer: game FSM, ball physics and scoring, updated once per frame_tick.
// Define PONG_AI_EN to let the right paddle chase the ball instead of following r_up/r_dn.
module pong_game_ctrl import pong_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        l_up,
  input  logic        l_dn,
  input  logic        r_up,
  input  logic        r_dn,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [10:0] pad_l_y,
  output logic [10:0] pad_r_y,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic [2:0]  game_state
);
  state_t     state;
  logic [5:0] cnt;
  logic       vx_neg, vy_neg, pend;
  logic       pad_en, hold_done, r_up_eff, r_dn_eff;
  logic       l_ov, r_ov, out_l, out_r, vx_new, vy_new;
  scoord_t    xn, yn;
  coord_t     x_new, y_new;

  assign game_state = state;
  assign pad_en     = (state == SERVE) || (state == PLAY) || (state == POINT);
  assign hold_done  = (cnt == HOLD_FRM - 6'd1);

`ifdef PONG_AI_EN
  scoord_t ai_d;
  assign ai_d     = s12(pad_r_y + (PADDLE_H >> 1)) - s12(ball_y + (BALL_SZ >> 1));
  assign r_up_eff = ai_d > s12(PAD_SPD >> 1);
  assign r_dn_eff = ai_d < -s12(PAD_SPD >> 1);
`else
  assign r_up_eff = r_up;
  assign r_dn_eff = r_dn;
`endif

  pong_paddle u_pad_l (.clk(clk), .rst(rst), .tick(frame_tick), .en(pad_en),
                       .up(l_up), .dn(l_dn), .y(pad_l_y));
  pong_paddle u_pad_r (.clk(clk), .rst(rst), .tick(frame_tick), .en(pad_en),
                       .up(r_up_eff), .dn(r_dn_eff), .y(pad_r_y));

  // any shared pixel row between ball and paddle counts as a hit
  assign l_ov = (ball_y + BALL_SZ > pad_l_y) && (ball_y < pad_l_y + PADDLE_H);
  assign r_ov = (ball_y + BALL_SZ > pad_r_y) && (ball_y < pad_r_y + PADDLE_H);

  always_comb begin
    xn     = s12(ball_x) + (vx_neg ? -s12(BALL_SPD) : s12(BALL_SPD));
    yn     = s12(ball_y) + (vy_neg ? -s12(BALL_SPD) : s12(BALL_SPD));
    x_new  = xn[CW-1:0];
    y_new  = yn[CW-1:0];
    vx_new = vx_neg;
    vy_new = vy_neg;
    out_l  = 1'b0;
    out_r  = 1'b0;
    if (yn <= 12'sd0)               begin y_new = '0;        vy_new = 1'b0; end
    else if (yn >= s12(BALL_YMAX))  begin y_new = BALL_YMAX; vy_new = 1'b1; end
    if (vx_neg && xn <= s12(L_STOP) && l_ov)        begin x_new = L_STOP; vx_new = 1'b0; end
    else if (!vx_neg && xn >= s12(R_STOP) && r_ov)  begin x_new = R_STOP; vx_new = 1'b1; end
    else if (xn < 12'sd0)                           out_l = 1'b1;
    else if (xn > s12(BALL_XMAX))                   out_r = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ball_x  <= BALL_X0;
      ball_y  <= BALL_Y0;
      vx_neg  <= 1'b0;
      vy_neg  <= 1'b0;
      score_l <= '0;
      score_r <= '0;
      pend    <= 1'b0;
    end else begin
      if (frame_tick) pend <= 1'b0;
      else if (start) pend <= 1'b1;
      if (frame_tick) begin
        case (state)
          IDLE: if (pend) begin
            state  <= SERVE;
            cnt    <= '0;
            ball_x <= BALL_X0;
            ball_y <= BALL_Y0;
          end
          SERVE: begin
            ball_x <= BALL_X0;
            ball_y <= BALL_Y0;
            if (hold_done) begin state <= PLAY; cnt <= '0; end
            else cnt <= cnt + 6'd1;
          end
          PLAY: if (out_l || out_r) begin
            // ball freezes where it was; next serve heads toward the player who missed
            state  <= POINT;
            cnt    <= '0;
            vx_neg <= out_l;
            if (out_l && score_r != SCORE_MAX) score_r <= score_r + 4'd1;
            if (out_r && score_l != SCORE_MAX) score_l <= score_l + 4'd1;
          end else begin
            ball_x <= x_new;
            ball_y <= y_new;
            vx_neg <= vx_new;
            vy_neg <= vy_new;
          end
          POINT: if (hold_done) begin
            cnt <= '0;
            if (score_l == WIN_SCORE || score_r == WIN_SCORE) state <= GAME_OVER;
            else begin
              state  <= SERVE;
              ball_x <= BALL_X0;
              ball_y <= BALL_Y0;
            end
          end else cnt <= cnt + 6'd1;
          GAME_OVER: if (pend) begin
            state   <= SERVE;
            cnt     <= '0;
            score_l <= '0;
            score_r <= '0;
            vx_neg  <= 1'b0;
            ball_x  <= BALL_X0;
            ball_y  <= BALL_Y0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: a frame-level game model checked against the DUT every cycle,
// plus hand-worked expectations along a scripted game.
module tb_pong_game_ctrl;
  logic        clk = 1'b0, rst = 1'b0, frame_tick = 1'b0, start = 1'b0;
  logic        l_up = 1'b0, l_dn = 1'b0, r_up = 1'b0, r_dn = 1'b0;
  logic [10:0] ball_x, ball_y, pad_l_y, pad_r_y;
  logic [3:0]  score_l, score_r;
  logic [2:0]  game_state;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;
  int m_st, m_hold, m_bx, m_by, m_vx, m_vy, m_pl, m_pr, m_sl, m_sr;
  bit m_pend;

  pong_game_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .l_up(l_up), .l_dn(l_dn), .r_up(r_up), .r_dn(r_dn),
    .ball_x(ball_x), .ball_y(ball_y), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .score_l(score_l), .score_r(score_r), .game_state(game_state)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // every cycle the registered outputs must equal the model's frame state
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({game_state, ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r} !==
          {3'(m_st), 11'(m_bx), 11'(m_by), 11'(m_pl), 11'(m_pr), 4'(m_sl), 4'(m_sr)}) begin
        n_bad++;
        $display("FAIL cycle_cmp t=%0t got st=%0d ball=(%0d,%0d) pads=%0d/%0d score=%0d:%0d want st=%0d ball=(%0d,%0d) pads=%0d/%0d score=%0d:%0d",
                 $time, game_state, ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r,
                 m_st, m_bx, m_by, m_pl, m_pr, m_sl, m_sr);
      end
    end
  end

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic bit overlaps(int by, int py);
    for (int r = by; r < by + 10; r++)
      if (r >= py && r < py + 80) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_hold = 0; m_bx = 395; m_by = 295; m_vx = 4; m_vy = 4;
    m_pl = 260; m_pr = 260; m_sl = 0; m_sr = 0; m_pend = 1'b0;
  endtask

  task automatic enter(int s);
    m_st = s; m_hold = 0;
    if (s == S_SERVE) begin m_bx = 395; m_by = 295; end
  endtask

  task automatic model_step(input bit lu, input bit ld, input bit ru, input bit rd);
    int ox, oy, opl, opr, nx, ny, nvx, nvy, dr;
    ox = m_bx; oy = m_by; opl = m_pl; opr = m_pr;
    if (m_st == S_SERVE || m_st == S_PLAY || m_st == S_POINT) begin
      m_pl = clampi(m_pl + 6 * (int'(ld) - int'(lu)), 0, 520);
`ifdef PONG_AI_EN
      dr = (opr + 40) - (oy + 5);
      if (dr > 3)       m_pr = clampi(m_pr - 6, 0, 520);
      else if (dr < -3) m_pr = clampi(m_pr + 6, 0, 520);
`else
      dr = 0;
      m_pr = clampi(m_pr + 6 * (int'(rd) - int'(ru)), 0, 520);
`endif
    end
    case (m_st)
      S_IDLE:  if (m_pend) enter(S_SERVE);
      S_SERVE: begin m_hold++; if (m_hold == 60) enter(S_PLAY); end
      S_PLAY: begin
        nx = ox + m_vx; ny = oy + m_vy; nvx = m_vx; nvy = m_vy;
        if (ny <= 0)         begin ny = 0;   nvy = 4;  end
        else if (ny >= 590)  begin ny = 590; nvy = -4; end
        if (m_vx < 0 && nx <= 26 && overlaps(oy, opl))          begin nx = 26;  nvx = 4;  end
        else if (m_vx > 0 && nx + 10 >= 774 && overlaps(oy, opr)) begin nx = 764; nvx = -4; end
        if (nx < 0) begin
          m_sr = (m_sr == 15) ? 15 : m_sr + 1; m_vx = -4; enter(S_POINT);
        end else if (nx > 790) begin
          m_sl = (m_sl == 15) ? 15 : m_sl + 1; m_vx = 4; enter(S_POINT);
        end else begin
          m_bx = nx; m_by = ny; m_vx = nvx; m_vy = nvy;
        end
      end
      S_POINT: begin
        m_hold++;
        if (m_hold == 60) enter((m_sl == 5 || m_sr == 5) ? S_OVER : S_SERVE);
      end
      S_OVER: if (m_pend) begin m_sl = 0; m_sr = 0; m_vx = 4; enter(S_SERVE); end
      default: ;
    endcase
    m_pend = 1'b0;
  endtask

  // called at a falling edge; returns at a falling edge
  task automatic tick(input bit lu, input bit ld, input bit ru, input bit rd);
    l_up = lu; l_dn = ld; r_up = ru; r_dn = rd; frame_tick = 1'b1;
    @(posedge clk);
    model_step(lu, ld, ru, rd);
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(int n, input bit lu, input bit ld, input bit ru, input bit rd);
    repeat (n) tick(lu, ld, ru, rd);
  endtask

  task automatic press_start();
    start = 1'b1;
    @(posedge clk); m_pend = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
  endtask

  // trk: follow the ball; otherwise run to the far half so the ball gets past
  task automatic steer(input int pad, input bit trk, output bit up, output bit dn);
    int d;
    if (trk) begin
      d = (pad + 40) - (m_by + 5);
      up = d > 3; dn = d < -3;
    end else begin
      up = (m_by + 5 >= 300); dn = !up;
    end
  endtask

  initial begin
    bit lu, ld, ru, rd;
    int guard;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_state", game_state, S_IDLE);
    check("rst_ball_x", ball_x, 395);
    check("rst_ball_y", ball_y, 295);
    check("rst_pads", {pad_l_y, pad_r_y}, {11'd260, 11'd260});
    check("rst_scores", {score_l, score_r}, 0);
    rst = 1'b1; chk_en = 1'b1;
    @(negedge clk);

    ticks(3, 0, 0, 0, 0);
    check("idle_no_start", game_state, S_IDLE);
    press_start();
    tick(0, 0, 0, 0);
    check("serve_entry", game_state, S_SERVE);
    ticks(59, 0, 0, 0, 0);
    check("serve_hold59", game_state, S_SERVE);
    tick(0, 0, 0, 0);
    check("play_entry", game_state, S_PLAY);
    check("play_ball0", {ball_x, ball_y}, {11'd395, 11'd295});
    tick(0, 0, 0, 0);
    check("play_ball1", {ball_x, ball_y}, {11'd399, 11'd299});

    // bounces off the bottom wall at frame 74, then passes under the right paddle
    ticks(97, 0, 0, 0, 0);
    check("pre_miss_ball", {ball_x, ball_y}, {11'd787, 11'd494});
    check("pre_miss_state", game_state, S_PLAY);
    tick(0, 0, 0, 0);
    check("miss_state", game_state, S_POINT);
    check("miss_score_l", score_l, 1);
    check("miss_score_r", score_r, 0);
    check("miss_frozen", {ball_x, ball_y}, {11'd787, 11'd494});

    ticks(10, 1, 1, 1, 1);
    check("pad_l_both", pad_l_y, 260);
`ifndef PONG_AI_EN
    check("pad_r_both", pad_r_y, 260);
`endif
    ticks(43, 0, 1, 0, 0);
    check("pad_l_dn43", pad_l_y, 518);
    tick(0, 1, 0, 0);
    check("pad_l_clamp_hi", pad_l_y, 520);
    tick(0, 1, 0, 0);
    check("pad_l_stay_hi", pad_l_y, 520);
    ticks(4, 0, 0, 0, 0);
    check("point_hold59", game_state, S_POINT);
    tick(0, 0, 0, 0);
    check("point_to_serve", game_state, S_SERVE);
    check("serve_centred", {ball_x, ball_y}, {11'd395, 11'd295});

    ticks(86, 1, 0, 0, 0);
    check("pad_l_up86", pad_l_y, 4);
    tick(1, 0, 0, 0);
    check("pad_l_clamp_lo", pad_l_y, 0);

    guard = 0;
    while (!(m_st == S_POINT && (m_sl == 5 || m_sr == 5)) && guard < 6000) begin
      steer(m_pl, 1'b1, lu, ld); steer(m_pr, 1'b0, ru, rd);
      tick(lu, ld, ru, rd);
      guard++;
    end
    if (guard >= 6000) begin
      n_cmp++; n_bad++;
      $display("FAIL game1_timeout: got %0d frames, want fewer than 6000", guard);
    end
    check("win_reached", int'(score_l == 4'd5 || score_r == 4'd5), 1);
    ticks(59, 0, 0, 0, 0);
    check("final_point_hold", game_state, S_POINT);
    tick(0, 0, 0, 0);
    check("game_over", game_state, S_OVER);
    ticks(5, 0, 0, 0, 0);
    check("game_over_hold", game_state, S_OVER);
    press_start();
    tick(0, 0, 0, 0);
    check("restart_state", game_state, S_SERVE);
    check("restart_scores", {score_l, score_r}, 0);
    ticks(60, 0, 0, 0, 0);
    check("restart_play", game_state, S_PLAY);
    tick(0, 0, 0, 0);
    check("restart_dir_x", ball_x, 399);

    // right player tracks, left dodges: right should score and the serve heads left
    guard = 0;
    while (!(m_st == S_POINT && m_sr >= 1) && guard < 6000) begin
      steer(m_pl, 1'b0, lu, ld); steer(m_pr, 1'b1, ru, rd);
      tick(lu, ld, ru, rd);
      guard++;
    end
    if (guard >= 6000) begin
      n_cmp++; n_bad++;
      $display("FAIL game2_timeout: got %0d frames, want fewer than 6000", guard);
    end
    check("r_scores", score_r, 1);
    check("r_point_state", game_state, S_POINT);
    ticks(60, 0, 0, 0, 0);
    check("r_serve", game_state, S_SERVE);
    ticks(60, 0, 0, 0, 0);
    check("r_play", game_state, S_PLAY);
    tick(0, 0, 0, 0);
    check("serve_toward_left", ball_x, 391);

    // start left pending, then a mid-cycle reset must wipe it along with everything else
    start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    chk_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_state", game_state, S_IDLE);
    check("async_ball", {ball_x, ball_y}, {11'd395, 11'd295});
    check("async_pads", {pad_l_y, pad_r_y}, {11'd260, 11'd260});
    check("async_scores", {score_l, score_r}, 0);
    model_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); chk_en = 1'b1;
    tick(0, 0, 0, 0);
    check("pend_cleared", game_state, S_IDLE);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
